// File: rtl/rx_arb_pkg.sv
// Shared widths and entry field layout for the receiver data arbiter.
// Entries are packed as {id, data, ts} with ts in the low bits.
package rx_arb_pkg;

  localparam int unsigned DATA_W = 17;
  localparam int unsigned TS_W   = 24;

  localparam int unsigned TS_LSB   = 0;
  localparam int unsigned DATA_LSB = TS_LSB + TS_W;
  localparam int unsigned ID_LSB   = DATA_LSB + DATA_W;

  // ENTRY_W depends on the receiver-index width chosen by the instantiating block.
  function automatic int unsigned entry_w(input int unsigned id_w);
    return id_w + DATA_W + TS_W;
  endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Synchronous FIFO with registered level/full/empty and a combinational head read.
// Push while full and pop while empty are ignored.
module rx_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AddrW  = $clog2(Depth);
  localparam int unsigned LevelW = AddrW + 1;

  logic [Width-1:0]  mem_q [Depth];
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0] level_q, level_d;
  logic              full_q, empty_q;
  logic              do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (!do_push && do_pop) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == LevelW'(Depth));
      empty_q <= (level_d == '0);
    end
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/receiver_data_arbiter.sv
// Captures decoded BMC words per receiver, round-robin arbitrates them into one FIFO.
// Optional RX_ARB_DROP_COUNT_EN adds per-channel saturating drop counters.
module receiver_data_arbiter
  import rx_arb_pkg::*;
#(
  parameter int unsigned NB_RECEIVERS = 4,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned ID_W         = $clog2(NB_RECEIVERS)
) (
  input  logic                           clk_96MHz,
  input  logic                           reset_n,
  input  logic [NB_RECEIVERS-1:0]        rx_data_availible,
  input  logic [NB_RECEIVERS*DATA_W-1:0] rx_decoded_data,
  input  logic [NB_RECEIVERS*TS_W-1:0]   rx_timestamp,
  input  logic                           out_ready,
  input  logic                           clear_overrun,
  output logic                           out_valid,
  output logic [ID_W-1:0]                out_rx_id,
  output logic [DATA_W-1:0]              out_data,
  output logic [TS_W-1:0]                out_timestamp,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic [NB_RECEIVERS-1:0]        overrun
`ifdef RX_ARB_DROP_COUNT_EN
  ,
  output logic [NB_RECEIVERS*8-1:0]      drop_count
`endif
);

  localparam int unsigned ENTRY_W = entry_w(ID_W);

  logic [NB_RECEIVERS-1:0] prev_av_q, pending_q, pending_d, overrun_q, overrun_d;
  logic [NB_RECEIVERS-1:0] cap, ovr_evt;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d, grant_idx, search_idx;
  logic                    grant_vld;
  logic [DATA_W-1:0]       slot_data_q [NB_RECEIVERS];
  logic [TS_W-1:0]         slot_ts_q   [NB_RECEIVERS];
  logic                    fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]      push_entry, head_entry;

  assign cap = rx_data_availible & ~prev_av_q;

  // First pending slot at or after rr_ptr, wrapping; the full flag is registered.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    search_idx = '0;
    for (int k = 0; k < int'(NB_RECEIVERS); k++) begin
      search_idx = ID_W'((32'(rr_ptr_q) + 32'(k)) % NB_RECEIVERS);
      if (!fifo_full && !grant_vld && pending_q[search_idx]) begin
        grant_vld = 1'b1;
        grant_idx = search_idx;
      end
    end
    rr_ptr_d = grant_vld ? ID_W'((32'(grant_idx) + 32'd1) % NB_RECEIVERS) : rr_ptr_q;
  end

  // A capture on a granted slot is not a loss: the old word leaves this cycle.
  always_comb begin
    pending_d = pending_q;
    ovr_evt   = '0;
    for (int i = 0; i < int'(NB_RECEIVERS); i++) begin
      if (grant_vld && grant_idx == ID_W'(i)) pending_d[i] = 1'b0;
      if (cap[i]) begin
        ovr_evt[i]   = pending_q[i] & ~(grant_vld && grant_idx == ID_W'(i));
        pending_d[i] = 1'b1;
      end
    end
    overrun_d = (clear_overrun ? '0 : overrun_q) | ovr_evt;
  end

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      prev_av_q <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      rr_ptr_q  <= '0;
      for (int i = 0; i < int'(NB_RECEIVERS); i++) begin
        slot_data_q[i] <= '0;
        slot_ts_q[i]   <= '0;
      end
    end else begin
      prev_av_q <= rx_data_availible;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      rr_ptr_q  <= rr_ptr_d;
      for (int i = 0; i < int'(NB_RECEIVERS); i++) begin
        if (cap[i]) begin
          slot_data_q[i] <= rx_decoded_data[DATA_W*i +: DATA_W];
          slot_ts_q[i]   <= rx_timestamp[TS_W*i +: TS_W];
        end
      end
    end
  end

  assign push_entry = {grant_idx, slot_data_q[grant_idx], slot_ts_q[grant_idx]};

  rx_sync_fifo #(
    .Width (ENTRY_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_96MHz),
    .rst_ni  (reset_n),
    .push_i  (grant_vld),
    .wdata_i (push_entry),
    .pop_i   (out_ready),
    .rdata_o (head_entry),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid     = ~fifo_empty;
  assign out_rx_id     = head_entry[ID_LSB +: ID_W];
  assign out_data      = head_entry[DATA_LSB +: DATA_W];
  assign out_timestamp = head_entry[TS_LSB +: TS_W];
  assign overrun       = overrun_q;

`ifdef RX_ARB_DROP_COUNT_EN
  logic [7:0] drop_cnt_q [NB_RECEIVERS];

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NB_RECEIVERS); i++) drop_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NB_RECEIVERS); i++) begin
        if (clear_overrun) begin
          drop_cnt_q[i] <= ovr_evt[i] ? 8'd1 : 8'd0;
        end else if (ovr_evt[i] && drop_cnt_q[i] != 8'hFF) begin
          drop_cnt_q[i] <= drop_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    drop_count = '0;
    for (int i = 0; i < int'(NB_RECEIVERS); i++) drop_count[8*i +: 8] = drop_cnt_q[i];
  end
`endif

endmodule

// File: doc/receiver_data_arbiter.md
Name: receiver_data_arbiter

Overview:
- Collects decoded BMC words from NB_RECEIVERS single-receiver channels.
- Each channel delivers a data_availible strobe, a 17-bit decoded word and a 24-bit timestamp.
- Captures each word into a per-channel holding slot, then round-robin arbitrates the slots into one shared FIFO.
- Presents the FIFO to the downstream transport (UART/SPI packer) over a valid/ready handshake, tagged with the receiver index.

Parameters:
- NB_RECEIVERS, 4, number of receiver channels (2..8).
- FIFO_DEPTH, 16, output FIFO entries (power of 2, >=4).
- ID_W, 2, receiver index width, = clog2(NB_RECEIVERS).

Ports:
- clk_96MHz  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rx_data_availible  input  NB_RECEIVERS  per-channel data-ready level from the decoders.
- rx_decoded_data  input  NB_RECEIVERS*17  packed decoded words; channel i at [17*i+:17].
- rx_timestamp  input  NB_RECEIVERS*24  packed last-data timestamps; channel i at [24*i+:24].
- out_ready  input  1  downstream accepts the head entry.
- clear_overrun  input  1  single-cycle clear of all overrun flags.
- out_valid  output  1  FIFO not empty.
- out_rx_id  output  ID_W  receiver index of the head entry.
- out_data  output  17  decoded word of the head entry.
- out_timestamp  output  24  timestamp of the head entry.
- fifo_level  output  clog2(FIFO_DEPTH)+1  current occupancy.
- overrun  output  NB_RECEIVERS  sticky per-channel flag: a word was lost.

Behaviour:
- Reset (reset_n low, async): all outputs and state go to 0, namely out_valid, out_rx_id, out_data, out_timestamp, fifo_level, overrun, pending, rr_ptr, edge registers and FIFO pointers.
- Capture:
  - prev_av[i] registers rx_data_availible[i].
  - Capture event on channel i: rx_data_availible[i]=1 and prev_av[i]=0.
  - On a capture event, slot[i] <= {data_i, ts_i} and pending[i] <= 1 at the end of the same cycle.
- Arbitration:
  - Each cycle, if any pending and the FIFO is not full, grant the first pending index searching from rr_ptr upward with wrap.
  - The granted slot is pushed to the FIFO, pending[g] is cleared and rr_ptr <= (g+1) mod NB_RECEIVERS.
  - At most one push per cycle.
  - No grant occurs while full, even if a pop happens in the same cycle (full flag is registered).
- Simultaneous capture and grant on the same channel: the old slot contents are pushed, the new word is latched and pending stays 1.
- Capture while pending=1 and not granted: the slot is overwritten with the newest word and overrun[i] <= 1.
- clear_overrun clears all flags. A new overrun on the same cycle wins (flag stays 1).
- FIFO handshake:
  - Pop occurs when out_valid && out_ready.
  - Outputs show the head entry combinationally from FIFO storage and hold stable while out_valid && !out_ready.
  - Push and pop in the same cycle leave fifo_level unchanged.
- Latency: capture edge in cycle t, grant/push in t+1, out_valid=1 in t+2 (FIFO was empty, no contention).
- Pointers wrap modulo FIFO_DEPTH. full = (level==FIFO_DEPTH), empty = (level==0).
- Backpressure: the FIFO holds FIFO_DEPTH entries plus NB_RECEIVERS pending slots. Beyond that, the newest word per channel is kept and older ones are dropped and flagged.
- Reset mid-operation discards all pending and FIFO contents immediately.

Optional Feature:
- Macro: RX_ARB_DROP_COUNT_EN.
- When defined:
  - Adds output drop_count, NB_RECEIVERS*8 bits, with one 8-bit saturating counter per channel.
  - The counter increments on every overrun event and saturates at 255.
  - clear_overrun also zeroes the counters.
- When undefined: the port and counters are absent. Only the sticky overrun flags exist.

Decomposition:
- Shared package/header rx_arb_pkg holds:
  - constants DATA_W=17, TS_W=24;
  - entry width ENTRY_W = ID_W+DATA_W+TS_W;
  - field offsets for {id, data, ts} packing.
- One sub-module: rx_sync_fifo.
  - Parameterised width/depth, registered level and full/empty.
  - Push/pop interface, head read combinational.
- Arbiter, capture slots and overrun logic stay in receiver_data_arbiter.

Test Plan:
1. Single word: ch1 rises with data 0x1ABCD, ts 0x123456. Expect out_valid at t+2 with rx_id=1, data=0x1ABCD, ts=0x123456. Pop with ready=1; level returns to 0.
2. Simultaneous: all 4 channels rise in the same cycle, rr_ptr=0. Expect FIFO order ids 0,1,2,3 on consecutive cycles and rr_ptr ending at 0. A repeat with rr_ptr=2 gives order 2,3,0,1.
3. Full FIFO: hold out_ready=0 and feed 16 words. Expect fifo_level=16 and no push on the 17th. The pending word is kept; after one pop it is pushed on the next cycle.
4. Overrun: with FIFO full and ready=0, ch2 rises twice with data 0x00001 then 0x00002. Expect overrun=4'b0100 and the later drained entry data=0x00002. clear_overrun then gives overrun=0.
5. Capture+grant collision: ch0 is pending and being granted in the same cycle as a new rise with 0x0000F. Expect the old word pushed, pending[0]=1, and 0x0000F pushed next.
6. Async reset: assert reset_n=0 mid-drain with level=5. All outputs go to 0 immediately without a clock; after release the block accepts new words normally.
